// File: rtl/warblade_pkg.sv
// Shared warblade constants and the bullet Y-advance helper.
package warblade_pkg;

  localparam int COORD_W         = 11;
  localparam int N_SLOT          = 3;
  localparam int HALF_SHIP_WIDTH = 24;
  localparam logic [11:0] Y_SHIP = 12'd680;

  // Descend by step on 12 bits so a wrap past 2047 stays visible; never jump over the ship line.
  function automatic logic [11:0] adv_y(input logic [COORD_W-1:0] y, input logic [11:0] step);
    logic [11:0] s;
    s = {1'b0, y} + step;
    return (({1'b0, y} < Y_SHIP) && (s > Y_SHIP)) ? Y_SHIP : s;
  endfunction

endpackage

// File: rtl/en_bullet_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requests allowed by mask, searching from ptr_i.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o,
  output logic [PW-1:0] idx_o,
  output logic [PW-1:0] ptr_nxt_o
);

  // First eligible requester at or after the pointer, wrapping; pointer moves one past the winner.
  always_comb begin
    int c;
    c         = 0;
    gnt_o     = '0;
    vld_o     = 1'b0;
    idx_o     = '0;
    for (int off = 0; off < N; off++) begin
      c = (int'(ptr_i) + off) % N;
      if (en_i && !vld_o && req_i[c] && mask_i[c]) begin
        gnt_o[c] = 1'b1;
        vld_o    = 1'b1;
        idx_o    = PW'(c);
      end else begin
        vld_o    = vld_o;
      end
    end
    if (vld_o) begin
      ptr_nxt_o = PW'((int'(idx_o) + 1) % N);
    end else begin
      ptr_nxt_o = ptr_i;
    end
  end

endmodule

// File: rtl/en_bullet_sched.sv
// Enemy bullet scheduler: grants fire requests into three bullet slots and moves them down per frame.
// Optional per-requester frame cooldown is built when BULLET_COOLDOWN_EN is defined.
module en_bullet_sched
  import warblade_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int STEP     = 4,
  parameter int Y_LIMIT  = 767,
  parameter int COOLDOWN = 30
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [N_REQ-1:0]           fire_req,
  input  logic [COORD_W*N_REQ-1:0]   enemy_X,
  input  logic [COORD_W*N_REQ-1:0]   enemy_Y,
  input  logic [N_SLOT-1:0]          hit_clr,
  output logic [N_REQ-1:0]           fire_gnt,
  output logic [COORD_W-1:0]         enBullet_X_1,
  output logic [COORD_W-1:0]         enBullet_X_2,
  output logic [COORD_W-1:0]         enBullet_X_3,
  output logic [COORD_W-1:0]         enBullet_Y_1,
  output logic [COORD_W-1:0]         enBullet_Y_2,
  output logic [COORD_W-1:0]         enBullet_Y_3,
  output logic [N_SLOT-1:0]          slot_active
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [11:0] STEP12  = 12'(STEP);
  localparam logic [11:0] YLIM12  = 12'(Y_LIMIT);

  logic [COORD_W-1:0] x_q [N_SLOT];
  logic [COORD_W-1:0] x_d [N_SLOT];
  logic [COORD_W-1:0] y_q [N_SLOT];
  logic [COORD_W-1:0] y_d [N_SLOT];
  logic [11:0]        ny_s [N_SLOT];
  logic [COORD_W-1:0] ex_s [N_REQ];
  logic [COORD_W-1:0] ey_s [N_REQ];
  logic [N_SLOT-1:0]  act_q, act_d, free_sel_s;
  logic [PW-1:0]      ptr_q, ptr_d, gnt_idx_s;
  logic [N_REQ-1:0]   elig_s, blk_s, gnt_s;
  logic               gnt_en_s, gnt_vld_s;

  // Unpack the enemy coordinate buses per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      ex_s[i] = enemy_X[i*COORD_W +: COORD_W];
      ey_s[i] = enemy_Y[i*COORD_W +: COORD_W];
    end
  end

  // Lowest clear bit of act_q as a one-hot; zero when every slot is busy.
  assign free_sel_s = ~act_q & (act_q + N_SLOT'(1));
  assign gnt_en_s   = rst & ~frame_tick & (|free_sel_s);
  assign elig_s     = ~blk_s;
  assign fire_gnt   = gnt_s;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .en_i      (gnt_en_s),
    .req_i     (fire_req),
    .mask_i    (elig_s),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_s),
    .vld_o     (gnt_vld_s),
    .idx_o     (gnt_idx_s),
    .ptr_nxt_o (ptr_d)
  );

`ifdef BULLET_COOLDOWN_EN
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  logic [CW-1:0] cd_q [N_REQ];
  logic [CW-1:0] cd_d [N_REQ];

  // Cooldown reloads on a grant and counts frames down to zero.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      blk_s[i] = |cd_q[i];
      if (gnt_s[i]) begin
        cd_d[i] = CW'(COOLDOWN);
      end else if (frame_tick && blk_s[i]) begin
        cd_d[i] = cd_q[i] - CW'(1);
      end else begin
        cd_d[i] = cd_q[i];
      end
    end
  end

  // Cooldown counter registers.
  always_ff @(posedge pclk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (!rst) begin
        cd_q[i] <= '0;
      end else begin
        cd_q[i] <= cd_d[i];
      end
    end
  end
`else
  assign blk_s = '0;
`endif

  // A new bullet owns its free slot; otherwise a hit retires before any frame advance is considered.
  always_comb begin
    for (int k = 0; k < N_SLOT; k++) begin
      x_d[k]   = x_q[k];
      y_d[k]   = y_q[k];
      act_d[k] = act_q[k];
      ny_s[k]  = adv_y(y_q[k], STEP12);
      if (gnt_vld_s && free_sel_s[k]) begin
        x_d[k]   = ex_s[gnt_idx_s];
        y_d[k]   = ey_s[gnt_idx_s] + 11'd1;
        act_d[k] = 1'b1;
      end else if (hit_clr[k]) begin
        x_d[k]   = '0;
        y_d[k]   = '0;
        act_d[k] = 1'b0;
      end else if (frame_tick && act_q[k]) begin
        if (ny_s[k][11] || (ny_s[k] > YLIM12)) begin
          x_d[k]   = '0;
          y_d[k]   = '0;
          act_d[k] = 1'b0;
        end else begin
          y_d[k]   = ny_s[k][COORD_W-1:0];
        end
      end else begin
        act_d[k] = act_q[k];
      end
    end
  end

  // Slot and pointer registers with synchronous active-low reset.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      act_q <= '0;
      ptr_q <= '0;
      for (int k = 0; k < N_SLOT; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      act_q <= act_d;
      ptr_q <= ptr_d;
      for (int k = 0; k < N_SLOT; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  assign slot_active  = act_q;
  assign enBullet_X_1 = x_q[0];
  assign enBullet_X_2 = x_q[1];
  assign enBullet_X_3 = x_q[2];
  assign enBullet_Y_1 = y_q[0];
  assign enBullet_Y_2 = y_q[1];
  assign enBullet_Y_3 = y_q[2];

endmodule

// File: tb/tb_en_bullet_sched.sv
// Bench for en_bullet_sched: directed scenarios plus a randomized run against a slot-level model.
module tb_en_bullet_sched;

  localparam int N    = 4;
  localparam int STEP = 4;
  localparam int YL   = 767;
  localparam int CD   = 2;
`ifdef BULLET_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  fire_req = 4'd0;
  logic [43:0] enemy_X = 44'd0;
  logic [43:0] enemy_Y = 44'd0;
  logic [2:0]  hit_clr = 3'd0;
  logic [3:0]  fire_gnt;
  logic [10:0] x1, x2, x3, y1, y2, y3;
  logic [2:0]  slot_active;

  int checks = 0;
  int errors = 0;

  // model: three bullet slots, next requester to search from, per-requester frames of cooldown
  int   m_x[3], m_y[3];
  bit   m_act[3];
  int   m_ptr;
  int   m_cd[4];
  int   gi, gs;
  bit   have_prev = 1'b0;
  logic [3:0]  exp_g;
  logic [65:0] exp_xy;
  logic [2:0]  exp_act;

  en_bullet_sched #(.N_REQ(N), .STEP(STEP), .Y_LIMIT(YL), .COOLDOWN(CD)) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .fire_req(fire_req),
    .enemy_X(enemy_X), .enemy_Y(enemy_Y), .hit_clr(hit_clr), .fire_gnt(fire_gnt),
    .enBullet_X_1(x1), .enBullet_X_2(x2), .enBullet_X_3(x3),
    .enBullet_Y_1(y1), .enBullet_Y_2(y2), .enBullet_Y_3(y3),
    .slot_active(slot_active)
  );

  always #5 pclk = ~pclk;

  task automatic model_update();
    int ny;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin m_x[k] = 0; m_y[k] = 0; m_act[k] = 1'b0; end
      for (int i = 0; i < 4; i++) m_cd[i] = 0;
      m_ptr = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (k == gs) begin
          m_x[k] = int'(enemy_X[11*gi +: 11]);
          m_y[k] = (int'(enemy_Y[11*gi +: 11]) + 1) % 2048;
          m_act[k] = 1'b1;
        end else if (hit_clr[k]) begin
          m_x[k] = 0; m_y[k] = 0; m_act[k] = 1'b0;
        end else if (frame_tick && m_act[k]) begin
          ny = m_y[k] + STEP;
          if (m_y[k] < 680 && ny > 680) ny = 680;
          if (ny > YL) begin m_x[k] = 0; m_y[k] = 0; m_act[k] = 1'b0; end
          else m_y[k] = ny;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (CD_EN && i == gi) m_cd[i] = CD;
        else if (frame_tick && m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
      end
      if (gi >= 0) m_ptr = (gi + 1) % N;
    end
  endtask

  task automatic predict();
    gi = -1; gs = -1;
    for (int k = 0; k < 3; k++) if (!m_act[k] && gs < 0) gs = k;
    if (rst && !frame_tick && gs >= 0)
      for (int off = 0; off < N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (gi < 0 && fire_req[c] && m_cd[c] == 0) gi = c;
      end
    if (gi < 0) gs = -1;
    exp_g   = (gi < 0) ? 4'd0 : (4'd1 << gi);
    exp_act = {m_act[2], m_act[1], m_act[0]};
    exp_xy  = {11'(m_x[0]), 11'(m_x[1]), 11'(m_x[2]), 11'(m_y[0]), 11'(m_y[1]), 11'(m_y[2])};
  endtask

  // One clock: retire the previous cycle into the model, drive new inputs, predict this cycle.
  task automatic cyc(input logic r, input logic ft, input logic [3:0] req, input logic [2:0] hc);
    @(negedge pclk);
    if (have_prev) model_update();
    have_prev  = 1'b1;
    rst        = r;
    frame_tick = ft;
    fire_req   = req;
    hit_clr    = hc;
    #1;
    predict();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 4'd0, 3'd0);
    cyc(1'b0, 1'b0, 4'd0, 3'd0);
  endtask

  task automatic test_reset();
    do_reset();
    if (slot_active !== 3'b000) begin errors++; $display("FAIL reset_active: got %b expected 000", slot_active); end
    checks++;
    if ({x1, x2, x3, y1, y2, y3} !== 66'd0) begin errors++; $display("FAIL reset_coords: got %h expected 0", {x1, x2, x3, y1, y2, y3}); end
    checks++;
    if (fire_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", fire_gnt); end
    checks++;
  endtask

  task automatic test_single();
    enemy_X = {11'd0, 11'd0, 11'd0, 11'd100};
    enemy_Y = {11'd0, 11'd0, 11'd0, 11'd200};
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
    if (fire_gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", fire_gnt); end
    checks++;
    cyc(1'b1, 1'b0, 4'b0000, 3'd0);
    if (fire_gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0000", fire_gnt); end
    checks++;
    if (slot_active !== 3'b001 || x1 !== 11'd100 || y1 !== 11'd201) begin
      errors++; $display("FAIL single_slot: got act=%b x=%0d y=%0d expected act=001 x=100 y=201", slot_active, x1, y1);
    end
    checks++;
  endtask

  task automatic test_fill();
    logic [3:0] want [4];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100; want[3] = 4'b0000;
    do_reset();
    enemy_X = {11'd40, 11'd30, 11'd20, 11'd10};
    enemy_Y = {11'd400, 11'd300, 11'd200, 11'd100};
    for (int t = 0; t < 4; t++) begin
      cyc(1'b1, 1'b0, 4'b1111, 3'd0);
      if (fire_gnt !== want[t]) begin errors++; $display("FAIL fill_gnt%0d: got %b expected %b", t, fire_gnt, want[t]); end
      checks++;
    end
    cyc(1'b1, 1'b0, 4'b1111, 3'b010);
    if (fire_gnt !== 4'b0000) begin errors++; $display("FAIL fill_busy_hit: got %b expected 0000", fire_gnt); end
    checks++;
    cyc(1'b1, 1'b0, 4'b1111, 3'd0);
    if (fire_gnt !== 4'b1000 || slot_active !== 3'b101) begin
      errors++; $display("FAIL fill_refill: got gnt=%b act=%b expected gnt=1000 act=101", fire_gnt, slot_active);
    end
    checks++;
    cyc(1'b1, 1'b0, 4'b0000, 3'd0);
    if (slot_active !== 3'b111 || x2 !== 11'd40 || y2 !== 11'd401) begin
      errors++; $display("FAIL fill_slot2: got act=%b x=%0d y=%0d expected act=111 x=40 y=401", slot_active, x2, y2);
    end
    checks++;
  endtask

  task automatic test_clamp();
    logic [10:0] want [3];
    want[0] = 11'd678; want[1] = 11'd680; want[2] = 11'd684;
    do_reset();
    enemy_X = {11'd0, 11'd0, 11'd0, 11'd77};
    enemy_Y = {11'd0, 11'd0, 11'd0, 11'd677};
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
    for (int t = 0; t < 3; t++) begin
      cyc(1'b1, (t < 2) ? 1'b1 : 1'b0, 4'b0000, 3'd0);
      if (y1 !== want[t]) begin errors++; $display("FAIL clamp_y%0d: got %0d expected %0d", t, y1, want[t]); end
      checks++;
    end
  endtask

  task automatic test_retire();
    do_reset();
    enemy_X = {11'd0, 11'd0, 11'd66, 11'd55};
    enemy_Y = {11'd0, 11'd0, 11'd300, 11'd764};
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
    cyc(1'b1, 1'b0, 4'b0010, 3'd0);
    cyc(1'b1, 1'b1, 4'b0000, 3'd0);
    if (y1 !== 11'd765 || y2 !== 11'd301) begin errors++; $display("FAIL retire_load: got y1=%0d y2=%0d expected 765 301", y1, y2); end
    checks++;
    cyc(1'b1, 1'b1, 4'b0000, 3'b010);
    if (slot_active !== 3'b010 || x1 !== 11'd0 || y1 !== 11'd0 || y2 !== 11'd305) begin
      errors++; $display("FAIL retire_bottom: got act=%b x1=%0d y1=%0d y2=%0d expected 010 0 0 305", slot_active, x1, y1, y2);
    end
    checks++;
    cyc(1'b1, 1'b0, 4'b0000, 3'd0);
    if (slot_active !== 3'b000 || x2 !== 11'd0 || y2 !== 11'd0) begin
      errors++; $display("FAIL retire_hit_tick: got act=%b x2=%0d y2=%0d expected 000 0 0", slot_active, x2, y2);
    end
    checks++;
  endtask

  task automatic test_cooldown();
    do_reset();
    enemy_X = {11'd0, 11'd0, 11'd0, 11'd9};
    enemy_Y = {11'd0, 11'd0, 11'd0, 11'd9};
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
    if (fire_gnt !== 4'b0001) begin errors++; $display("FAIL cd_first: got %b expected 0001", fire_gnt); end
    checks++;
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
`ifdef BULLET_COOLDOWN_EN
    if (fire_gnt !== 4'b0000) begin errors++; $display("FAIL cd_blocked: got %b expected 0000", fire_gnt); end
    checks++;
    cyc(1'b1, 1'b1, 4'b0001, 3'd0);
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
    if (fire_gnt !== 4'b0000) begin errors++; $display("FAIL cd_one_frame: got %b expected 0000", fire_gnt); end
    checks++;
    cyc(1'b1, 1'b1, 4'b0001, 3'd0);
    cyc(1'b1, 1'b0, 4'b0001, 3'd0);
    if (fire_gnt !== 4'b0001) begin errors++; $display("FAIL cd_release: got %b expected 0001", fire_gnt); end
    checks++;
`else
    if (fire_gnt !== 4'b0001) begin errors++; $display("FAIL cd_regrant: got %b expected 0001", fire_gnt); end
    checks++;
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int t = 0; t < 3; t++) cyc(1'b1, 1'b0, 4'b1111, 3'd0);
    cyc(1'b0, 1'b0, 4'b1111, 3'd0);
    if (slot_active !== 3'b111 || fire_gnt !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_assert: got act=%b gnt=%b expected 111 0000", slot_active, fire_gnt);
    end
    checks++;
    cyc(1'b0, 1'b0, 4'b1111, 3'd0);
    if (slot_active !== 3'b000 || fire_gnt !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_clear: got act=%b gnt=%b expected 000 0000", slot_active, fire_gnt);
    end
    checks++;
    cyc(1'b1, 1'b0, 4'b1111, 3'd0);
    if (fire_gnt !== 4'b0001) begin errors++; $display("FAIL mid_rst_first: got %b expected 0001", fire_gnt); end
    checks++;
  endtask

  task automatic test_random();
    logic r, ft;
    logic [3:0] rq;
    logic [2:0] hc;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < 4; i++) begin
        enemy_X[11*i +: 11] = 11'($urandom_range(0, 2047));
        enemy_Y[11*i +: 11] = 11'($urandom_range(0, 780));
      end
      r  = ($urandom_range(0, 63) != 0);
      ft = ($urandom_range(0, 5) == 0);
      rq = 4'($urandom);
      hc = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      cyc(r, ft, rq, hc);
      if (fire_gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt t=%0d: got %b expected %b", t, fire_gnt, exp_g); end
      checks++;
      if (slot_active !== exp_act) begin errors++; $display("FAIL rnd_act t=%0d: got %b expected %b", t, slot_active, exp_act); end
      checks++;
      if ({x1, x2, x3, y1, y2, y3} !== exp_xy) begin
        errors++; $display("FAIL rnd_xy t=%0d: got %h expected %h", t, {x1, x2, x3, y1, y2, y3}, exp_xy);
      end
      checks++;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_x[k] = 0; m_y[k] = 0; m_act[k] = 1'b0; end
    for (int i = 0; i < 4; i++) m_cd[i] = 0;
    m_ptr = 0; gi = -1; gs = -1;
    test_reset();
    test_single();
    test_fill();
    test_clamp();
    test_retire();
    test_cooldown();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
